alu_rr_arbiter: RTL
===================

Name: alu_rr_arbiter

Overview:
- Shares one combinational 32-bit ALU (A, B, Cin, 3-bit opcode, 64-bit Out) between NUM_REQ requesters.
- Round-robin arbitration over valid/ready request channels; drives registered operands to the ALU and captures its result.
- Returns the result with the requester ID on one valid/ready response channel.
- Sits between the execution clients and the shared ALU instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 32, operand width
- OP_W, 3, opcode width
- ID_W, $clog2(NUM_REQ), requester ID width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- req_a  in  NUM_REQ*DATA_W  packed operand A, requester i at [i*DATA_W +: DATA_W]
- req_b  in  NUM_REQ*DATA_W  packed operand B
- req_op  in  NUM_REQ*OP_W  packed opcodes
- req_cin  in  NUM_REQ  per-requester carry-in
- alu_a  out  DATA_W  to ALU A
- alu_b  out  DATA_W  to ALU B
- alu_op  out  OP_W  to ALU opcode
- alu_cin  out  1  to ALU Cin
- alu_out  in  2*DATA_W  from ALU Out
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  2*DATA_W  captured ALU result
- rsp_id  out  ID_W  requester index of the result

Behaviour:
- Reset: state IDLE, rr pointer 0, req_ready 0, rsp_valid 0, rsp_data 0, rsp_id 0, alu_a/alu_b/alu_op/alu_cin 0. Reset mid-operation abandons the in-flight op; no response is issued.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE: if any req_valid is set, grant the first set bit at or after the rr pointer, wrapping modulo NUM_REQ.
  - req_ready[g] is asserted combinationally that cycle; the handshake completes the same cycle.
  - Operands are registered into alu_* and g into rsp_id.
  - rr pointer becomes (g+1) mod NUM_REQ; go to EXEC.
  - With no valid request, stay in IDLE and hold alu_* unchanged.
- EXEC: alu_* are stable and the ALU settles.
  - At the clock edge, capture alu_out into rsp_data, set rsp_valid, go to RESP.
- RESP: hold rsp_valid, rsp_data and rsp_id stable until rsp_ready.
  - On rsp_valid && rsp_ready: clear rsp_valid, go to IDLE.
  - No new grant happens in RESP (single op in flight).
- req_ready is 0 in EXEC and RESP. Requesters must hold valid and payload until ready.
- Latency: accept at cycle T, rsp_valid at T+2; minimum issue interval is 3 cycles.
- Fairness: a continuously-valid requester waits at most NUM_REQ-1 grants.
- The rr pointer only advances on a grant. Simultaneous valids resolve by rr order only, never by a fixed priority.
- rsp_data is the full 2*DATA_W ALU output, unmodified; the block does not interpret opcodes.

Optional Feature:
- Macro ALU_ARB_WAIT_EN.
- Defined: adds state WAIT between EXEC and the capture, sampling alu_out one cycle later (T+3 rsp_valid, 4-cycle issue interval). This supports a registered or multicycle ALU.
- Undefined: WAIT state and its logic are absent; behaviour is exactly as above.

Decomposition:
- Package alu_arb_pkg:
  - state enum (IDLE, EXEC, RESP, WAIT)
  - localparams for DATA_W/OP_W defaults
  - opcode width constant shared with the ALU
- One sub-module, rr_pick: combinational round-robin selector. Inputs are the request vector and pointer; outputs are a one-hot grant and its index. It is reusable by other shared-resource arbiters.

Test Plan:
- Bench ALU model is alu_out = A+B+Cin zero-extended. Req0 only, A=0x4E, B=0x1E, op=000, cin=0 -> req_ready[0] in accept cycle T; rsp_valid at T+2 with rsp_data=0x6C, rsp_id=0.
- All four valid simultaneously with pointer 0 (A=0x46, B=0x3C) -> grants in order 0,1,2,3, then 0 again; each rsp_data=0x82 with matching rsp_id.
- rsp_ready held 0 for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id stable; no req_ready asserted; release -> IDLE the next cycle.
- Req2 and req3 valid after last grant to 3 -> pointer wraps to 0, req2 granted before req3.
- rst asserted during EXEC -> next cycle all outputs 0, state IDLE, no rsp_valid for the aborted op.
- ALU_ARB_WAIT_EN defined, single request 0x4E/0x1E -> rsp_valid at T+3, rsp_data=0x6C.

Source files
------------

// File: rtl/alu_rr_arbiter_pkg.sv
// Shared types and default widths for the round-robin ALU arbiter.
// The WAIT state is only used when ALU_ARB_WAIT_EN is defined.
package alu_arb_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ALU_OP_W   = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2,
      WAIT = 2'd3
   } arb_state_e;

endpackage : alu_arb_pkg

// File: rtl/alu_rr_arbiter_if.sv
// Request, shared-ALU and response channels of the arbiter in one bundle.
// The arbiter uses the slave modport; clients and the ALU use the master modport.
interface alu_rr_arbiter_if
   import alu_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int OP_W    = ALU_OP_W,
   parameter int ID_W    = $clog2(NUM_REQ)
) ();

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*DATA_W-1:0] req_a;
   logic [NUM_REQ*DATA_W-1:0] req_b;
   logic [NUM_REQ*OP_W-1:0]   req_op;
   logic [NUM_REQ-1:0]        req_cin;

   logic [DATA_W-1:0]         alu_a;
   logic [DATA_W-1:0]         alu_b;
   logic [OP_W-1:0]           alu_op;
   logic                      alu_cin;
   logic [2*DATA_W-1:0]       alu_out;

   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [2*DATA_W-1:0]       rsp_data;
   logic [ID_W-1:0]           rsp_id;

   modport slave (
      input  req_valid, req_a, req_b, req_op, req_cin,
      output req_ready,
      output alu_a, alu_b, alu_op, alu_cin,
      input  alu_out,
      output rsp_valid, rsp_data, rsp_id,
      input  rsp_ready
   );

   modport master (
      output req_valid, req_a, req_b, req_op, req_cin,
      input  req_ready,
      input  alu_a, alu_b, alu_op, alu_cin,
      output alu_out,
      input  rsp_valid, rsp_data, rsp_id,
      output rsp_ready
   );

endinterface : alu_rr_arbiter_if

// File: rtl/alu_rr_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr_i,
// wrapping modulo N. Reusable by any shared-resource arbiter.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  grant_o,
   output logic [IW-1:0] idx_o,
   output logic          valid_o
);

   int pos;

   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
      grant_o = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      pos     = 0;
      for (int off = 0; off < N; off++) begin
         pos = int'(ptr_i) + off;
         if (pos >= N) pos = pos - N;
         if (!valid_o && req_i[pos]) begin
            valid_o      = 1'b1;
            grant_o[pos] = 1'b1;
            idx_o        = IW'(pos);
         end
      end
   end

endmodule : rr_pick

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NUM_REQ requesters.
// Define ALU_ARB_WAIT_EN to insert a WAIT state before capturing alu_out.
module alu_rr_arbiter
   import alu_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int OP_W    = ALU_OP_W,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input logic              clk,
   input logic              rst,
   alu_rr_arbiter_if.slave  bus
);

   arb_state_e          state_q;
   logic [ID_W-1:0]     ptr_q, ptr_d;
   logic [DATA_W-1:0]   alu_a_q, alu_b_q;
   logic [OP_W-1:0]     alu_op_q;
   logic                alu_cin_q;
   logic                rsp_valid_q;
   logic [2*DATA_W-1:0] rsp_data_q;
   logic [ID_W-1:0]     rsp_id_q;

   logic [NUM_REQ-1:0]  grant;
   logic [ID_W-1:0]     gidx;
   logic                gvalid;

   rr_pick #(.N(NUM_REQ), .IW(ID_W)) u_pick (
      .req_i   (bus.req_valid),
      .ptr_i   (ptr_q),
      .grant_o (grant),
      .idx_o   (gidx),
      .valid_o (gvalid)
   );

   assign ptr_d = (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + ID_W'(1);

   // Ready is only offered in IDLE, so at most one handshake completes per op.
   assign bus.req_ready = (state_q == IDLE) ? grant : '0;

   always_ff @(posedge clk) begin
      // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_op_q    <= '0;
         alu_cin_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_id_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (gvalid) begin
                  alu_a_q   <= bus.req_a[int'(gidx)*DATA_W +: DATA_W];
                  alu_b_q   <= bus.req_b[int'(gidx)*DATA_W +: DATA_W];
                  alu_op_q  <= bus.req_op[int'(gidx)*OP_W +: OP_W];
                  alu_cin_q <= bus.req_cin[gidx];
                  rsp_id_q  <= gidx;
                  ptr_q     <= ptr_d;
                  state_q   <= EXEC;
               end
            end
`ifdef ALU_ARB_WAIT_EN
            EXEC: state_q <= WAIT;
            WAIT: begin
               rsp_data_q  <= bus.alu_out;
               rsp_valid_q <= 1'b1;
               state_q     <= RESP;
            end
`else
            EXEC: begin
               rsp_data_q  <= bus.alu_out;
               rsp_valid_q <= 1'b1;
               state_q     <= RESP;
            end
`endif
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.alu_a     = alu_a_q;
   assign bus.alu_b     = alu_b_q;
   assign bus.alu_op    = alu_op_q;
   assign bus.alu_cin   = alu_cin_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_id    = rsp_id_q;

endmodule : alu_rr_arbiter
